fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 38 +++
 rtl/fifo_sync_param.sv | 140 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 32'd8;
    localparam int unsigned DEPTH_DEF  = 32'd64;

    // Ceiling log2, evaluated at elaboration time for pointer widths.
    function automatic int unsigned log2_f(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 32'd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // The count must represent 0..DEPTH inclusive, hence one bit beyond the address.
    function automatic int unsigned cnt_w_f(input int unsigned depth);
        return log2_f(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, registered synchronous read port.
module fifo_ram #(
    parameter int unsigned DATA_W = 32'd8,
    parameter int unsigned DEPTH  = 32'd64,
    parameter int unsigned ADDR_W = 32'd6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; deliberately not reset so it maps onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; a same-address write on the same edge returns the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data and occupancy count.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned AF_THRESH = DEPTH - 32'd8,
    parameter int unsigned AE_THRESH = 32'd8,
    localparam int unsigned ADDR_W   = log2_f(DEPTH),
    localparam int unsigned CNT_W    = cnt_w_f(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] buf_in_i,
    output logic [DATA_W-1:0] buf_out_o,
    output logic [CNT_W-1:0]  fifo_cntr_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic              clr_err_i,
    output logic              overflow_o,
    output logic              underflow_o,
`endif
    output logic              almost_full_o
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_ok_s, wr_ok_s;
    logic              empty_s, full_s;

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign full_s  = (count_q == CNT_W'(DEPTH));

    // A read frees a slot on the same edge, so a full FIFO still accepts wr alongside rd.
    assign rd_ok_s = rd_i & ~empty_s;
    assign wr_ok_s = wr_i & (~full_s | rd_ok_s);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_ok_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (buf_in_i),
        .re_i    (rd_ok_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_out_o)
    );

    // Status is decoded from the registered count only, never from rd/wr.
    assign fifo_cntr_o    = count_q;
    assign empty_o        = empty_s;
    assign full_o         = full_s;
    assign almost_empty_o = (32'(count_q) <= AE_THRESH);
    assign almost_full_o  = (32'(count_q) >= AF_THRESH);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a set condition outranks clr_err in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_i & full_s & ~rd_i) begin
            overflow_d = 1'b1;
        end else if (clr_err_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_i & empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err_i) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (DEPTH=64, AF=56, AE=8); covers both FIFO_ERR_FLAGS_EN builds.
module tb_fifo_sync_param;

    localparam int DEPTH = 64;
    localparam int AF    = 56;
    localparam int AE    = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       wr_i, rd_i, clr_err_i;
    logic [7:0] buf_in_i;
    logic [7:0] buf_out_o;
    logic [6:0] fifo_cntr_o;
    logic       empty_o, full_o, almost_empty_o, almost_full_o;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow_o, underflow_o;
`endif

    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] sb_q [$];
    int         m_cnt;
    logic [7:0] m_out;
    logic       m_ov, m_uf;

    always #5 clk_i = ~clk_i;

    fifo_sync_param #(
        .DATA_W    (32'd8),
        .DEPTH     (32'd64),
        .AF_THRESH (32'd56),
        .AE_THRESH (32'd8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_i           (wr_i),
        .rd_i           (rd_i),
        .buf_in_i       (buf_in_i),
        .buf_out_o      (buf_out_o),
        .fifo_cntr_o    (fifo_cntr_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
`ifdef FIFO_ERR_FLAGS_EN
        .clr_err_i      (clr_err_i),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
`endif
        .almost_full_o  (almost_full_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".buf_out"}, 32'(buf_out_o), 32'(m_out));
        check_eq({ph, ".cnt"}, 32'(fifo_cntr_o), 32'(m_cnt));
        check_eq({ph, ".empty"}, 32'(empty_o), 32'(m_cnt == 0));
        check_eq({ph, ".full"}, 32'(full_o), 32'(m_cnt == DEPTH));
        check_eq({ph, ".aempty"}, 32'(almost_empty_o), 32'(m_cnt <= AE));
        check_eq({ph, ".afull"}, 32'(almost_full_o), 32'(m_cnt >= AF));
`ifdef FIFO_ERR_FLAGS_EN
        check_eq({ph, ".ovf"}, 32'(overflow_o), 32'(m_ov));
        check_eq({ph, ".udf"}, 32'(underflow_o), 32'(m_uf));
`endif
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt = 0;
        m_out = 8'h00;
        m_ov  = 1'b0;
        m_uf  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, predict, check just after the rising edge.
    task automatic cyc(input string ph, input logic w, input logic r, input logic [7:0] d,
                       input logic c);
        logic rok, wok;
        @(negedge clk_i);
        wr_i = w; rd_i = r; buf_in_i = d; clr_err_i = c;
        rok = r && (m_cnt != 0);
        wok = w && ((m_cnt != DEPTH) || rok);
        if (w && (m_cnt == DEPTH) && !r) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (r && (m_cnt == 0)) m_uf = 1'b1;
        else if (c) m_uf = 1'b0;
        if (rok) m_out = sb_q.pop_front();
        if (wok) sb_q.push_back(d);
        m_cnt = m_cnt + int'(wok) - int'(rok);
        @(posedge clk_i);
        #1;
        check_all(ph);
    endtask

    // Reset asserted in the low clock phase; outputs must respond with no clock edge.
    task automatic reset_pulse(input string ph);
        @(negedge clk_i);
        wr_i = 1'b0; rd_i = 1'b0; clr_err_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b1; wr_i = 1'b0; rd_i = 1'b0; clr_err_i = 1'b0; buf_in_i = 8'h00;
        model_reset();
        reset_pulse("rst_init");

        for (int i = 0; i < 64; i++) cyc("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) cyc("ovf", 1'b1, 1'b0, 8'hFF, 1'b0);
        cyc("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        cyc("clr", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 64; i++) cyc("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        cyc("udf", 1'b0, 1'b1, 8'h00, 1'b0);
        cyc("udf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        cyc("clr2", 1'b0, 1'b0, 8'h00, 1'b1);

        cyc("rw_empty", 1'b1, 1'b1, 8'h3C, 1'b0);
        cyc("rd_3c", 1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 10; i++) cyc("fill10", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 6; i++) cyc("rw10", 1'b1, 1'b1, 8'(8'h90 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc("drain10", 1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 64; i++) cyc("fill2", 1'b1, 1'b0, 8'(8'hC0 ^ i), 1'b0);
        for (int i = 0; i < 3; i++) cyc("rw_full", 1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 64; i++) cyc("drain2", 1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 20; i++) cyc("fill20", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        reset_pulse("rst_mid");
        cyc("wr_a5", 1'b1, 1'b0, 8'hA5, 1'b0);
        cyc("rd_a5", 1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
